// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage constants: next-PC select encodings, reset/exception vectors
// and instruction-memory size.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    NPC_PC4 = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_op_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
  localparam int unsigned IM_WORDS = 1024;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC target computation for sequential, branch, jump and jr
// flows; the caller applies exception/eret/stall priority on top of this.
module npc_calc
  import pc_fetch_pkg::*;
(
  input  logic [1:0]  npc_op_i,
  input  logic        branch_cond_i,
  input  logic [31:0] pc4_f_i,
  input  logic [31:0] pc_d_i,
  input  logic [15:0] imm16_d_i,
  input  logic [25:0] index_d_i,
  input  logic [31:0] rs_d_i,
  output logic [31:0] npc_o
);

  logic [31:0] br_target;
  logic [31:0] j_target;

  // Branch offset is relative to the delay slot (pc_D+4), in words.
  assign br_target = pc_d_i + 32'd4 + {{14{imm16_d_i[15]}}, imm16_d_i, 2'b00};
  assign j_target  = {pc_d_i[31:28], index_d_i, 2'b00};

  always_comb begin
    npc_o = pc4_f_i;
    unique case (npc_op_i)
      NPC_PC4: npc_o = pc4_f_i;
      NPC_BR:  npc_o = branch_cond_i ? br_target : pc4_f_i;
      NPC_J:   npc_o = j_target;
      NPC_JR:  npc_o = rs_d_i;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch-stage program counter: owns pc_F, applies exception/eret/stall priority
// over the D-stage next-PC select, and flags fetch validity and address faults.
module pc_fetch
  import pc_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        branch_cond,
  input  logic [31:0] pc_D,
  input  logic [15:0] imm16_D,
  input  logic [25:0] index_D,
  input  logic [31:0] rs_D,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_F,
  output logic [31:0] pc4_F,
  output logic        fetch_valid,
  output logic        addr_err_F
);

  localparam logic [32:0] WinLo = {1'b0, RESET_PC};
  localparam logic [32:0] WinHi = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic        valid_q;
  logic [31:0] npc;

  npc_calc u_npc_calc (
    .npc_op_i      (npc_op),
    .branch_cond_i (branch_cond),
    .pc4_f_i       (pc4_F),
    .pc_d_i        (pc_D),
    .imm16_d_i     (imm16_D),
    .index_d_i     (index_D),
    .rs_d_i        (rs_D),
    .npc_o         (npc)
  );

  always_comb begin
    pc_d = pc_q;
    if (exc_req) begin
      pc_d = EXC_VEC;
    end else if (eret_req) begin
      pc_d = epc;
    end else if (!stall) begin
      pc_d = npc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
    end
  end

  assign pc_F        = pc_q;
  assign pc4_F       = pc_q + 32'd4;
  assign fetch_valid = valid_q;
  // Window compare done in 33 bits so the upper bound cannot wrap.
  assign addr_err_F  = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} < WinLo) ||
                       ({1'b0, pc_q} >= WinHi);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: hand-computed expected PCs checked with immediate
// assertions after each clock edge.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_op;
  logic        branch_cond;
  logic [31:0] pc_D;
  logic [15:0] imm16_D;
  logic [25:0] index_D;
  logic [31:0] rs_D;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc_F;
  logic [31:0] pc4_F;
  logic        fetch_valid;
  logic        addr_err_F;

  int total = 0;
  int bad   = 0;

  pc_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .npc_op      (npc_op),
    .branch_cond (branch_cond),
    .pc_D        (pc_D),
    .imm16_D     (imm16_D),
    .index_D     (index_D),
    .rs_D        (rs_D),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .pc_F        (pc_F),
    .pc4_F       (pc4_F),
    .fetch_valid (fetch_valid),
    .addr_err_F  (addr_err_F)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] exp_pc, input logic exp_err);
    chk({tag, ".pc"}, pc_F, exp_pc);
    chk({tag, ".pc4"}, pc4_F, exp_pc + 32'd4);
    chk({tag, ".err"}, {31'd0, addr_err_F}, {31'd0, exp_err});
  endtask

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    npc_op      = 2'd0;
    branch_cond = 1'b0;
    pc_D        = 32'h0;
    imm16_D     = 16'h0;
    index_D     = 26'h0;
    rs_D        = 32'h0;
    exc_req     = 1'b0;
    eret_req    = 1'b0;
    epc         = 32'h0;

    // Reset held across edges, even with an exception request pending.
    #2;
    chk_pc("rst", 32'h3000, 1'b0);
    chk("rst.fv", {31'd0, fetch_valid}, 32'd0);
    exc_req = 1'b1;
    step();
    chk_pc("rst_exc", 32'h3000, 1'b0);
    chk("rst_exc.fv", {31'd0, fetch_valid}, 32'd0);
    exc_req = 1'b0;
    reset   = 1'b0;

    step();
    chk_pc("seq1", 32'h3004, 1'b0);
    chk("seq1.fv", {31'd0, fetch_valid}, 32'd1);
    step();
    chk_pc("seq2", 32'h3008, 1'b0);
    step();
    step();
    chk_pc("seq4", 32'h3010, 1'b0);

    // Stall three cycles with a J pending; J target 0x3080.
    stall   = 1'b1;
    npc_op  = 2'd2;
    pc_D    = 32'h0000_300C;
    index_D = 26'h000_0C20;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_pc("stall", 32'h3010, 1'b0);
      chk("stall.fv", {31'd0, fetch_valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    chk_pc("jump", 32'h3080, 1'b0);

    // J keeps pc_D[31:28].
    pc_D    = 32'hA000_0000;
    index_D = 26'h3FF_FFFF;
    step();
    chk_pc("jump_hi", 32'hAFFF_FFFC, 1'b1);

    // Branch backwards: 0x3020 + 4 - 8.
    npc_op      = 2'd1;
    pc_D        = 32'h0000_3020;
    imm16_D     = 16'hFFFE;
    branch_cond = 1'b1;
    step();
    chk_pc("br_taken", 32'h301C, 1'b0);
    branch_cond = 1'b0;
    step();
    chk_pc("br_not", 32'h3020, 1'b0);
    // Forward branch: 0x3020 + 4 + 0x40.
    imm16_D     = 16'h0010;
    branch_cond = 1'b1;
    step();
    chk_pc("br_fwd", 32'h3064, 1'b0);

    // JR targets and window boundaries.
    npc_op = 2'd3;
    rs_D   = 32'h0000_3002;
    step();
    chk_pc("jr_mis", 32'h3002, 1'b1);
    rs_D = 32'h0000_5000;
    step();
    chk_pc("jr_oob", 32'h5000, 1'b1);
    rs_D = 32'h0000_3FFC;
    step();
    chk_pc("jr_top", 32'h3FFC, 1'b0);
    rs_D = 32'h0000_4000;
    step();
    chk_pc("jr_end", 32'h4000, 1'b1);
    rs_D = 32'h0000_2FFC;
    step();
    chk_pc("jr_low", 32'h2FFC, 1'b1);

    // Wrap modulo 2^32.
    rs_D = 32'hFFFF_FFFC;
    step();
    chk_pc("jr_wrap", 32'hFFFF_FFFC, 1'b1);
    npc_op = 2'd0;
    step();
    chk_pc("wrap", 32'h0000_0000, 1'b1);

    // exc beats eret and stall.
    stall    = 1'b1;
    exc_req  = 1'b1;
    eret_req = 1'b1;
    epc      = 32'h0000_3040;
    step();
    chk_pc("exc", 32'h4180, 1'b1);
    exc_req = 1'b0;
    stall   = 1'b0;
    step();
    chk_pc("eret", 32'h3040, 1'b0);
    // eret also overrides stall.
    stall = 1'b1;
    epc   = 32'h0000_3050;
    step();
    chk_pc("eret_stall", 32'h3050, 1'b0);
    eret_req = 1'b0;
    stall    = 1'b0;

    // Reach 0x3100 then assert reset asynchronously mid-cycle.
    npc_op = 2'd3;
    rs_D   = 32'h0000_3100;
    step();
    chk_pc("pre_rst", 32'h3100, 1'b0);
    chk("pre_rst.fv", {31'd0, fetch_valid}, 32'd1);
    npc_op = 2'd0;
    #2;
    reset = 1'b1;
    #1;
    chk_pc("async_rst", 32'h3000, 1'b0);
    chk("async_rst.fv", {31'd0, fetch_valid}, 32'd0);
    step();
    reset = 1'b0;
    chk_pc("rst_hold", 32'h3000, 1'b0);
    step();
    chk_pc("post_rst", 32'h3004, 1'b0);
    chk("post_rst.fv", {31'd0, fetch_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
